// File: rtl/fir_pkg.sv
// Shared sizes, FSM encoding and tap-index helper for the coefficient-replay FIR.
package fir_pkg;
    localparam int FIR_W1    = 14;
    localparam int FIR_W2    = 35;
    localparam int FIR_L     = 33;
    localparam int FIR_SHIFT = 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        OUT  = 2'd3
    } fir_state_t;

    // A single-tap filter still needs a one-bit index.
    function automatic int tap_idx_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

    localparam int FIR_IDX_W = tap_idx_width(FIR_L);
endpackage

// File: rtl/fir_mac_unit.sv
// Signed W1 x W1 multiply feeding a wrapping W2 accumulator with synchronous clear and enable.
module fir_mac_unit #(
    parameter int W1 = 14,
    parameter int W2 = 35
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    input  logic [W1-1:0] a,
    input  logic [W1-1:0] b,
    output logic [W2-1:0] acc
);
    logic signed [2*W1-1:0] prod;
    logic        [W2-1:0]   prod_ext;
    logic        [W2-1:0]   acc_reg;

    assign prod     = $signed(a) * $signed(b);
    assign prod_ext = {{(W2-2*W1){prod[2*W1-1]}}, prod};
    assign acc      = acc_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_reg <= '0;
        end else if (clr) begin
            acc_reg <= '0;
        end else if (en) begin
            acc_reg <= acc_reg + prod_ext;
        end
    end
endmodule

// File: rtl/fir_coef_replay.sv
// Time-multiplexed FIR replaying a frozen LMS coefficient set, one MAC per cycle.
// Define FIR_REPLAY_SAT_EN to saturate y_scaled instead of wrapping it.
module fir_coef_replay
    import fir_pkg::*;
#(
    parameter int W1    = FIR_W1,
    parameter int W2    = FIR_W2,
    parameter int L     = FIR_L,
    parameter int SHIFT = FIR_SHIFT
)(
    input  logic          clk,
    input  logic          reset_n,
    input  logic          coef_valid,
    input  logic [W1-1:0] coef_data,
    input  logic          coef_last,
    output logic          coef_ready,
    input  logic          x_valid,
    input  logic [W1-1:0] x_in,
    output logic          x_ready,
    output logic          y_valid,
    output logic [W2-1:0] y_out,
    output logic [W1-1:0] y_scaled
);
    localparam int IDX_W = tap_idx_width(L);

    fir_state_t     state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] tap_reg;
    logic [W1-1:0]  f_reg [L];
    logic [W1-1:0]  x_reg [L];
    logic [W2-1:0]  y_out_reg;
    logic           y_valid_reg;
    logic [W2-1:0]  acc;

    logic coef_take;
    logic x_take;
    logic load_done;

    assign coef_ready = (state_reg == IDLE) || (state_reg == LOAD);
    assign x_ready    = (state_reg == IDLE);
    assign coef_take  = coef_valid && coef_ready;
    // A coefficient word arriving in IDLE wins over a simultaneous sample.
    assign x_take     = x_valid && (state_reg == IDLE) && !coef_valid;
    assign load_done  = coef_last || (idx_reg == IDX_W'(L-1));

    // Coefficient store: idx_reg is 0 whenever IDLE, so the first word lands in f[0].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < L; k++) f_reg[k] <= '0;
        end else if (coef_take) begin
            for (int k = 0; k < L; k++) begin
                if (idx_reg == IDX_W'(k)) f_reg[k] <= coef_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < L; k++) x_reg[k] <= '0;
        end else if (x_take) begin
            x_reg[0] <= x_in;
            for (int k = 1; k < L; k++) x_reg[k] <= x_reg[k-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            tap_reg     <= '0;
            y_out_reg   <= '0;
            y_valid_reg <= 1'b0;
        end else begin
            y_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (coef_valid) begin
                        if (coef_last || (L == 1)) begin
                            idx_reg <= '0;
                        end else begin
                            idx_reg   <= IDX_W'(1);
                            state_reg <= LOAD;
                        end
                    end else if (x_valid) begin
                        tap_reg   <= '0;
                        state_reg <= MAC;
                    end
                end
                LOAD: begin
                    if (coef_valid) begin
                        if (load_done) begin
                            idx_reg   <= '0;
                            state_reg <= IDLE;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                MAC: begin
                    if (tap_reg == IDX_W'(L-1)) begin
                        tap_reg   <= '0;
                        state_reg <= OUT;
                    end else begin
                        tap_reg <= tap_reg + 1'b1;
                    end
                end
                OUT: begin
                    y_out_reg   <= acc;
                    y_valid_reg <= 1'b1;
                    state_reg   <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    fir_mac_unit #(
        .W1 (W1),
        .W2 (W2)
    ) u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (x_take),
        .en      (state_reg == MAC),
        .a       (f_reg[tap_reg]),
        .b       (x_reg[tap_reg]),
        .acc     (acc)
    );

    assign y_out   = y_out_reg;
    assign y_valid = y_valid_reg;

`ifdef FIR_REPLAY_SAT_EN
    localparam logic signed [W2-1:0] SAT_HI = W2'(2**(W1-1) - 1);
    localparam logic signed [W2-1:0] SAT_LO = -SAT_HI - 1;

    logic signed [W2-1:0] y_shift;
    assign y_shift = $signed(y_out_reg) >>> SHIFT;

    always_comb begin
        y_scaled = y_shift[W1-1:0];
        if (y_shift > SAT_HI) begin
            y_scaled = {1'b0, {(W1-1){1'b1}}};
        end else if (y_shift < SAT_LO) begin
            y_scaled = {1'b1, {(W1-1){1'b0}}};
        end
    end
`else
    // Low W1 bits of an arithmetic shift are just a slice of y_out.
    assign y_scaled = y_out_reg[SHIFT +: W1];
`endif
endmodule

// File: tb/tb_fir_coef_replay.sv
// Directed self-checking bench for fir_coef_replay (honours FIR_REPLAY_SAT_EN if defined).
module tb_fir_coef_replay;
    logic        clk;
    logic        reset_n;
    logic        coef_valid;
    logic [13:0] coef_data;
    logic        coef_last;
    logic        coef_ready;
    logic        x_valid;
    logic [13:0] x_in;
    logic        x_ready;
    logic        y_valid;
    logic [34:0] y_out;
    logic [13:0] y_scaled;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

`ifdef FIR_REPLAY_SAT_EN
    localparam logic [13:0] BIG_FIRST_S = 14'd8191;
    localparam logic [13:0] BIG_LAST_S  = 14'd8191;
`else
    localparam logic [13:0] BIG_FIRST_S = 14'd1919;
    localparam logic [13:0] BIG_LAST_S  = 14'd12160;
`endif

    fir_coef_replay dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_last  (coef_last),
        .coef_ready (coef_ready),
        .x_valid    (x_valid),
        .x_in       (x_in),
        .x_ready    (x_ready),
        .y_valid    (y_valid),
        .y_out      (y_out),
        .y_scaled   (y_scaled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push_coef(input logic [13:0] d, input logic last);
        int n;
        n = 0;
        coef_valid = 1'b1;
        coef_data  = d;
        coef_last  = last;
        while (!coef_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("coef_ready_wait", coef_ready, 1);
        @(posedge clk); #1;
        coef_valid = 1'b0;
        coef_last  = 1'b0;
    endtask

    task automatic send_x(input logic [13:0] xv, input bit chk,
                          input logic [34:0] ey, input logic [13:0] es);
        int n;
        n = 0;
        x_valid = 1'b1;
        x_in    = xv;
        while (!x_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("x_ready_wait", x_ready, 1);
        @(posedge clk); #1;
        x_valid = 1'b0;
        if (chk) begin
            check("mac_coef_ready", coef_ready, 0);
            check("mac_x_ready", x_ready, 0);
            check("y_valid_one_cycle", y_valid, 0);
        end
        n = 0;
        while (!y_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (chk || n >= 100) check("latency", n, 34);
        if (chk) begin
            check("y_out", y_out, ey);
            check("y_scaled", y_scaled, es);
            check("out_x_ready", x_ready, 1);
            $display("sample x=%0d y_out=%0d y_scaled=%0d latency=%0d", xv, y_out, y_scaled, n);
        end
    endtask

    initial begin
        int pulses;
        reset_n    = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        coef_last  = 1'b0;
        x_valid    = 1'b0;
        x_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_y_valid", y_valid, 0);
        check("rst_y_out", y_out, 0);
        check("rst_y_scaled", y_scaled, 0);
        check("rst_coef_ready", coef_ready, 1);
        check("rst_x_ready", x_ready, 1);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 33 coefficients of 70, then a single 128 impulse walking down the line
        for (int i = 0; i < 33; i++) begin
            push_coef(14'd70, i == 32);
            if (i == 0) begin
                check("load_x_ready", x_ready, 0);
                check("load_coef_ready", coef_ready, 1);
            end
        end
        check("load_done_idle", x_ready, 1);
        send_x(14'd128, 1'b1, 35'd8960, 14'd70);
        for (int i = 0; i < 32; i++) send_x(14'd0, 1'b1, 35'd8960, 14'd70);
        send_x(14'd0, 1'b1, 35'd0, 14'd0);

        // Early coef_last on word 5 over the all-70 set
        for (int i = 1; i <= 5; i++) push_coef(14'(i), i == 5);
        check("early_last_idle", x_ready, 1);
        for (int i = 1; i <= 33; i++) begin
            if (i == 5)       send_x(14'd1, 1'b1, 35'd15, 14'd0);
            else if (i == 6)  send_x(14'd1, 1'b1, 35'd85, 14'd0);
            else if (i == 33) send_x(14'd1, 1'b1, 35'd1975, 14'd15);
            else              send_x(14'd1, 1'b0, 35'd0, 14'd0);
        end

        // Full-scale coefficients and samples
        for (int i = 0; i < 33; i++) push_coef(14'd8191, i == 32);
        for (int i = 0; i < 33; i++) begin
            if (i == 0)       send_x(14'd8191, 1'b1, 35'd67354593, BIG_FIRST_S);
            else if (i == 32) send_x(14'd8191, 1'b1, 35'd2214051873, BIG_LAST_S);
            else              send_x(14'd8191, 1'b0, 35'd0, 14'd0);
        end

        // coef_valid and x_valid together in IDLE: coefficient wins
        x_valid    = 1'b1;
        x_in       = 14'd8191;
        coef_valid = 1'b1;
        coef_data  = 14'd1;
        coef_last  = 1'b0;
        @(posedge clk); #1;
        check("both_coef_ready", coef_ready, 1);
        check("both_x_ready", x_ready, 0);
        for (int i = 1; i < 33; i++) begin
            push_coef(14'd1, i == 32);
            if (i == 16) check("both_mid_x_ready", x_ready, 0);
        end
        check("both_no_y_valid", y_valid, 0);
        check("both_back_idle", x_ready, 1);
        send_x(14'd8191, 1'b1, 35'd270303, 14'd2111);

        // Reset in MAC cycle 10 aborts the result and clears the coefficients
        x_valid = 1'b1;
        x_in    = 14'd3;
        @(posedge clk); #1;
        x_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_y_valid", y_valid, 0);
        check("abort_y_out", y_out, 0);
        check("abort_coef_ready", coef_ready, 1);
        check("abort_x_ready", x_ready, 1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (y_valid) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        send_x(14'd5, 1'b1, 35'd0, 14'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
